// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch unit and the control unit's decoders:
// PC-select encodings, fetch FSM states and default datapath widths.
package pc_fetch_unit_pkg;

  localparam int PC_BITS_DEF = 64;
  localparam int K_BITS_DEF  = 64;

  localparam logic [1:0] PCSEL_INC    = 2'b00;
  localparam logic [1:0] PCSEL_BRANCH = 2'b01;
  localparam logic [1:0] PCSEL_REG    = 2'b10;
  localparam logic [1:0] PCSEL_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_FAULT = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_next_calc.sv
// Next-PC calculator: picks the PC-select target and flags targets that are
// not word aligned. Purely combinational.
module pc_next_calc
  import pc_fetch_unit_pkg::*;
#(
  parameter int PC_BITS = PC_BITS_DEF,
  parameter int K_BITS  = K_BITS_DEF
) (
  input  logic [PC_BITS-1:0] pc_i,
  input  logic [1:0]         pc_sel_i,
  input  logic [K_BITS-1:0]  K_i,
  input  logic [PC_BITS-1:0] reg_target_i,
  output logic [PC_BITS-1:0] next_pc_o,
  output logic               misaligned_o
);

  logic [PC_BITS-1:0] kWord;
  logic [PC_BITS-1:0] branchOffset;

  // A wider K is truncated to the PC width; a narrower one is sign-extended
  // so that negative word offsets still branch backwards.
  generate
    if (K_BITS >= PC_BITS) begin : g_kTrunc
      assign kWord = K_i[PC_BITS-1:0];
    end else begin : g_kSext
      assign kWord = {{(PC_BITS-K_BITS){K_i[K_BITS-1]}}, K_i};
    end
  endgenerate

  // Word offset to byte offset; bits shifted out the top are simply lost.
  assign branchOffset = kWord << 2;

  // Select the candidate PC; all adds wrap modulo 2^PC_BITS.
  always_comb begin
    next_pc_o = pc_i;
    unique case (pc_sel_i)
      PCSEL_INC:    next_pc_o = pc_i + PC_BITS'(4);
      PCSEL_BRANCH: next_pc_o = pc_i + branchOffset;
      PCSEL_REG:    next_pc_o = reg_target_i;
      PCSEL_HOLD:   next_pc_o = pc_i;
      default:      next_pc_o = pc_i;
    endcase
  end

  assign misaligned_o = |next_pc_o[1:0];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch front end. Fetches one word via a
// req/ack handshake, holds it for the control unit while it executes, then
// commits the next PC when the control unit reports completion.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                 PC_BITS  = PC_BITS_DEF,
  parameter int                 K_BITS   = K_BITS_DEF,
  parameter logic [PC_BITS-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_BITS-1:0] imem_addr_o,
  output logic               imem_req_o,
  input  logic               imem_ack_i,
  input  logic [31:0]        imem_data_i,
  output logic [31:0]        instruction_o,
  output logic               instr_valid_o,
  input  logic               instr_done_i,
  input  logic [1:0]         pc_sel_i,
  input  logic [K_BITS-1:0]  K_i,
  input  logic [PC_BITS-1:0] reg_target_i,
  output logic [PC_BITS-1:0] pc_o,
  output logic [PC_BITS-1:0] pc_plus4_o,
  output logic               fault_o
);

  fetch_state_e       stateQ, stateD;
  logic [PC_BITS-1:0] pcQ, pcD;
  logic [31:0]        instrQ, instrD;
  logic               faultQ, faultD;

  logic [PC_BITS-1:0] nextPc;
  logic               nextMisaligned;

  pc_next_calc #(
    .PC_BITS(PC_BITS),
    .K_BITS (K_BITS)
  ) u_nextCalc (
    .pc_i        (pcQ),
    .pc_sel_i    (pc_sel_i),
    .K_i         (K_i),
    .reg_target_i(reg_target_i),
    .next_pc_o   (nextPc),
    .misaligned_o(nextMisaligned)
  );

  // State, PC, instruction and fault registers; reset restarts fetching.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= ST_FETCH;
      pcQ    <= RESET_PC;
      instrQ <= '0;
      faultQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
      instrQ <= instrD;
      faultQ <= faultD;
    end
  end

  // Next state: capture on ack in FETCH, commit or fault on done in EXEC.
  // Inputs outside their own state are ignored, so done wins over ack in EXEC.
  always_comb begin
    stateD = stateQ;
    pcD    = pcQ;
    instrD = instrQ;
    faultD = faultQ;
    unique case (stateQ)
      ST_FETCH: begin
        if (imem_ack_i) begin
          instrD = imem_data_i;
          stateD = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (instr_done_i) begin
          if (nextMisaligned) begin
            faultD = 1'b1;
            stateD = ST_FAULT;
          end else begin
            pcD    = nextPc;
            stateD = ST_FETCH;
          end
        end
      end
      ST_FAULT: begin
        stateD = ST_FAULT;
      end
      default: begin
        stateD = ST_FETCH;
      end
    endcase
  end

  // Handshake and status outputs; the request is masked while reset is held
  // so memory never sees a request from a unit that is being reset.
  always_comb begin
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    if (stateQ == ST_FETCH) begin
      imem_req_o = !reset;
    end
    if (stateQ == ST_EXEC) begin
      instr_valid_o = 1'b1;
    end
  end

  assign imem_addr_o   = pcQ;
  assign pc_o          = pcQ;
  assign pc_plus4_o    = pcQ + PC_BITS'(4);
  assign instruction_o = instrQ;
  assign fault_o       = faultQ;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

  logic        clock;
  logic        reset;
  logic [63:0] imem_addr_o;
  logic        imem_req_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic [31:0] instruction_o;
  logic        instr_valid_o;
  logic        instr_done_i;
  logic [1:0]  pc_sel_i;
  logic [63:0] K_i;
  logic [63:0] reg_target_i;
  logic [63:0] pc_o;
  logic [63:0] pc_plus4_o;
  logic        fault_o;

  logic [63:0] refPc;
  logic [1:0]  refSel;
  logic [63:0] refK;
  logic [63:0] refTgt;
  logic [63:0] refNext;
  logic        refMis;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit #(
    .PC_BITS (64),
    .K_BITS  (64),
    .RESET_PC(64'h0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_addr_o  (imem_addr_o),
    .imem_req_o   (imem_req_o),
    .imem_ack_i   (imem_ack_i),
    .imem_data_i  (imem_data_i),
    .instruction_o(instruction_o),
    .instr_valid_o(instr_valid_o),
    .instr_done_i (instr_done_i),
    .pc_sel_i     (pc_sel_i),
    .K_i          (K_i),
    .reg_target_i (reg_target_i),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .fault_o      (fault_o)
  );

  pc_next_calc #(
    .PC_BITS(64),
    .K_BITS (64)
  ) refCalc (
    .pc_i        (refPc),
    .pc_sel_i    (refSel),
    .K_i         (refK),
    .reg_target_i(refTgt),
    .next_pc_o   (refNext),
    .misaligned_o(refMis)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic commitPc(input logic [1:0] sel, input logic [63:0] k, input logic [63:0] tgt);
    pc_sel_i     = sel;
    K_i          = k;
    reg_target_i = tgt;
    instr_done_i = 1'b1;
    stepCycle();
    instr_done_i = 1'b0;
  endtask

  task automatic completeFetch(input logic [31:0] word);
    imem_data_i = word;
    imem_ack_i  = 1'b1;
    stepCycle();
    imem_ack_i  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    imem_ack_i = 1'b1;
    imem_data_i = 32'h8B020020;
    stepCycle();
    stepCycle();
    checks++; if (pc_o !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc actual=%0h expected=0", pc_o); end
    checks++; if (instruction_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_instr actual=%0h expected=0", instruction_o); end
    checks++; if (instr_valid_o !== 1'b0 || fault_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags valid=%0b fault=%0b expected 0/0", instr_valid_o, fault_o); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0) begin errors++; $display("[TB] FAIL first_req req=%0b addr=%0h expected 1/0", imem_req_o, imem_addr_o); end
    stepCycle();
    imem_ack_i = 1'b0;
    checks++; if (instr_valid_o !== 1'b1 || instruction_o !== 32'h8B020020) begin errors++; $display("[TB] FAIL first_exec valid=%0b instr=%0h expected 1/8b020020", instr_valid_o, instruction_o); end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("[TB] FAIL exec_req actual=%0b expected=0", imem_req_o); end
  endtask

  task automatic test_sequential();
    logic [63:0] expPc;
    logic [31:0] word;
    for (int i = 0; i < 3; i++) begin
      expPc = 64'(4 * (i + 1));
      word  = 32'hA000_0000 + 32'(i);
      commitPc(2'b00, 64'h0, 64'h0);
      checks++; if (pc_o !== expPc) begin errors++; $display("[TB] FAIL seq_pc actual=%0h expected=%0h", pc_o, expPc); end
      for (int w = 0; w < 3; w++) begin
        stepCycle();
        checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== expPc) begin errors++; $display("[TB] FAIL seq_wait req=%0b addr=%0h expected 1/%0h", imem_req_o, imem_addr_o, expPc); end
      end
      completeFetch(word);
      stepCycle();
      checks++; if (instruction_o !== word || instr_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL seq_instr instr=%0h valid=%0b expected %0h/1", instruction_o, instr_valid_o, word); end
    end
    checks++; if (pc_plus4_o !== 64'd16) begin errors++; $display("[TB] FAIL seq_plus4 actual=%0h expected=10", pc_plus4_o); end
  endtask

  task automatic test_branch();
    commitPc(2'b10, 64'h0, 64'h100);
    completeFetch(32'h1111_0000);
    commitPc(2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0);
    checks++; if (imem_addr_o !== 64'hF8 || imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL branch_neg addr=%0h req=%0b expected f8/1", imem_addr_o, imem_req_o); end
    completeFetch(32'h1111_0001);
    commitPc(2'b01, 64'h10, 64'h0);
    checks++; if (imem_addr_o !== 64'h138) begin errors++; $display("[TB] FAIL branch_pos addr=%0h expected=138", imem_addr_o); end
    completeFetch(32'h1111_0002);
    commitPc(2'b10, 64'h0, 64'h2000);
    checks++; if (imem_addr_o !== 64'h2000) begin errors++; $display("[TB] FAIL branch_reg addr=%0h expected=2000", imem_addr_o); end
    completeFetch(32'h1111_0003);
    commitPc(2'b11, 64'h0, 64'h0);
    checks++; if (pc_o !== 64'h2000 || imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL hold pc=%0h req=%0b expected 2000/1", pc_o, imem_req_o); end
    completeFetch(32'h1111_0004);
  endtask

  task automatic test_fault();
    commitPc(2'b10, 64'h0, 64'h2002);
    checks++; if (fault_o !== 1'b1 || pc_o !== 64'h2000) begin errors++; $display("[TB] FAIL fault_set fault=%0b pc=%0h expected 1/2000", fault_o, pc_o); end
    imem_ack_i = 1'b1;
    instr_done_i = 1'b1;
    pc_sel_i = 2'b00;
    stepCycle();
    stepCycle();
    imem_ack_i = 1'b0;
    instr_done_i = 1'b0;
    checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0 || fault_o !== 1'b1) begin errors++; $display("[TB] FAIL fault_sticky req=%0b valid=%0b fault=%0b expected 0/0/1", imem_req_o, instr_valid_o, fault_o); end
    checks++; if (pc_o !== 64'h2000 || pc_plus4_o !== 64'h2004) begin errors++; $display("[TB] FAIL fault_pc pc=%0h plus4=%0h expected 2000/2004", pc_o, pc_plus4_o); end
    reset = 1'b1;
    #1;
    checks++; if (fault_o !== 1'b0 || pc_o !== 64'h0) begin errors++; $display("[TB] FAIL fault_clear fault=%0b pc=%0h expected 0/0", fault_o, pc_o); end
    stepCycle();
    reset = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0) begin errors++; $display("[TB] FAIL fault_refetch req=%0b addr=%0h expected 1/0", imem_req_o, imem_addr_o); end
    completeFetch(32'h2222_0000);
  endtask

  task automatic test_wrap();
    commitPc(2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    checks++; if (pc_plus4_o !== 64'h0) begin errors++; $display("[TB] FAIL wrap_plus4 actual=%0h expected=0", pc_plus4_o); end
    completeFetch(32'h3333_0000);
    commitPc(2'b00, 64'h0, 64'h0);
    checks++; if (pc_o !== 64'h0 || fault_o !== 1'b0 || imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pc pc=%0h fault=%0b req=%0b expected 0/0/1", pc_o, fault_o, imem_req_o); end
  endtask

  task automatic test_spurious();
    instr_done_i = 1'b1;
    pc_sel_i = 2'b01;
    K_i = 64'h40;
    stepCycle();
    stepCycle();
    instr_done_i = 1'b0;
    checks++; if (pc_o !== 64'h0 || imem_req_o !== 1'b1) begin errors++; $display("[TB] FAIL done_in_fetch pc=%0h req=%0b expected 0/1", pc_o, imem_req_o); end
    completeFetch(32'h1234_5678);
    imem_data_i = 32'hDEAD_DEAD;
    imem_ack_i = 1'b1;
    stepCycle();
    stepCycle();
    imem_ack_i = 1'b0;
    checks++; if (instruction_o !== 32'h1234_5678 || instr_valid_o !== 1'b1 || pc_o !== 64'h0) begin errors++; $display("[TB] FAIL ack_in_exec instr=%0h valid=%0b pc=%0h expected 12345678/1/0", instruction_o, instr_valid_o, pc_o); end
    imem_data_i = 32'hBEEF_BEEF;
    imem_ack_i = 1'b1;
    commitPc(2'b00, 64'h0, 64'h0);
    imem_ack_i = 1'b0;
    checks++; if (pc_o !== 64'h4 || imem_req_o !== 1'b1 || instruction_o !== 32'h1234_5678) begin errors++; $display("[TB] FAIL done_and_ack pc=%0h req=%0b instr=%0h expected 4/1/12345678", pc_o, imem_req_o, instruction_o); end
  endtask

  task automatic test_reset_mid_fetch();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (imem_req_o !== 1'b0 || instruction_o !== 32'h0 || pc_o !== 64'h0) begin errors++; $display("[TB] FAIL mid_fetch_reset req=%0b instr=%0h pc=%0h expected 0/0/0", imem_req_o, instruction_o, pc_o); end
    stepCycle();
    reset = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 64'h0 || instr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_fetch_restart req=%0b addr=%0h valid=%0b expected 1/0/0", imem_req_o, imem_addr_o, instr_valid_o); end
  endtask

  task automatic test_next_calc();
    refPc = 64'h100; refSel = 2'b01; refK = 64'hFFFF_FFFF_FFFF_FFFE; refTgt = 64'h0;
    #1;
    checks++; if (refNext !== 64'hF8 || refMis !== 1'b0) begin errors++; $display("[TB] FAIL calc_branch next=%0h mis=%0b expected f8/0", refNext, refMis); end
    refPc = 64'h0; refSel = 2'b10; refTgt = 64'h3;
    #1;
    checks++; if (refNext !== 64'h3 || refMis !== 1'b1) begin errors++; $display("[TB] FAIL calc_misaligned next=%0h mis=%0b expected 3/1", refNext, refMis); end
    refPc = 64'h40; refSel = 2'b01; refK = 64'h4000_0000_0000_0001;
    #1;
    checks++; if (refNext !== 64'h44) begin errors++; $display("[TB] FAIL calc_shift_out next=%0h expected=44", refNext); end
  endtask

  initial begin
    reset = 1'b1;
    imem_ack_i = 1'b0;
    imem_data_i = 32'h0;
    instr_done_i = 1'b0;
    pc_sel_i = 2'b00;
    K_i = 64'h0;
    reg_target_i = 64'h0;
    refPc = 64'h0;
    refSel = 2'b00;
    refK = 64'h0;
    refTgt = 64'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_fault();
    test_wrap();
    test_spurious();
    test_reset_mid_fetch();
    test_next_calc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
